relational: RTL and testbench

RELATIONAL -- requirements
Module: relational

---
 rtl/relational_pkg.sv | 18 +
 rtl/relational_if.sv | 37 +++
 rtl/relational_cmp.sv | 43 ++++
 rtl/relational.sv | 68 ++++++
 tb/tb_relational.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/relational_pkg.sv
// Shared constants and result type for the relational comparator slice.
package relational_pkg;

  localparam int WIDTH_DEF = 1;
  localparam int WIDTH_MAX = 64;

  localparam logic CMP_UNSIGNED = 1'b0;
  localparam logic CMP_SIGNED   = 1'b1;

  typedef struct packed {
    logic gt;
    logic lt;
    logic eq;
  } cmp_res_t;

  localparam cmp_res_t CMP_RES_CLEAR = '{gt: 1'b0, lt: 1'b0, eq: 1'b0};

endpackage

// File: rtl/relational_if.sv
// Request/result bundle for the relational comparator.
// Extended ge/le/ne wires exist only with RELATIONAL_EXT_OUTPUTS_EN defined.
interface relational_if import relational_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF
) ();

  logic             in_valid;
  logic             cmp_signed;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             gt;
  logic             lt;
  logic             eq;
`ifdef RELATIONAL_EXT_OUTPUTS_EN
  logic             ge;
  logic             le;
  logic             ne;
`endif

  modport master (
    output in_valid, cmp_signed, a, b,
`ifdef RELATIONAL_EXT_OUTPUTS_EN
    input  ge, le, ne,
`endif
    input  out_valid, gt, lt, eq
  );

  modport slave (
    input  in_valid, cmp_signed, a, b,
`ifdef RELATIONAL_EXT_OUTPUTS_EN
    output ge, le, ne,
`endif
    output out_valid, gt, lt, eq
  );

endinterface

// File: rtl/relational_cmp.sv
// Combinational magnitude/equality compare of two WIDTH-bit operands,
// unsigned or two's-complement selected by cmp_signed.
module relational_cmp import relational_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cmp_signed,
  output cmp_res_t         res
);

  logic [WIDTH-1:0] a_key_s;
  logic [WIDTH-1:0] b_key_s;
  cmp_res_t         res_s;

  // Inverting the sign bit maps two's-complement order onto unsigned order.
  always_comb begin
    a_key_s = a;
    b_key_s = b;
    if (cmp_signed == CMP_SIGNED) begin
      a_key_s[WIDTH-1] = ~a[WIDTH-1];
      b_key_s[WIDTH-1] = ~b[WIDTH-1];
    end else begin
      a_key_s = a;
      b_key_s = b;
    end
  end

  // Exactly one flag is raised; equality uses the raw bits.
  always_comb begin
    res_s = CMP_RES_CLEAR;
    if (a == b) begin
      res_s.eq = 1'b1;
    end else if (a_key_s < b_key_s) begin
      res_s.lt = 1'b1;
    end else begin
      res_s.gt = 1'b1;
    end
  end

  assign res = res_s;

endmodule

// File: rtl/relational.sv
// Registered relational comparator with one-cycle latency.
// Define RELATIONAL_EXT_OUTPUTS_EN to add registered ge/le/ne outputs.
module relational import relational_pkg::*; #(
  parameter int WIDTH      = WIDTH_DEF,
  parameter bit SIGNED_DEF = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  relational_if.slave  bus
);

  logic     mode_s;
  cmp_res_t cmp_res_s;
  logic     out_valid_r;
  cmp_res_t res_r;

  // SIGNED_DEF forces signed mode when the integrator ties cmp_signed low.
  assign mode_s = bus.cmp_signed | SIGNED_DEF;

  relational_cmp #(.WIDTH(WIDTH)) u_cmp (
    .a          (bus.a),
    .b          (bus.b),
    .cmp_signed (mode_s),
    .res        (cmp_res_s)
  );

  // Valid pipeline stage and result flags held while in_valid is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      res_r       <= CMP_RES_CLEAR;
    end else begin
      out_valid_r <= bus.in_valid;
      if (bus.in_valid) begin
        res_r <= cmp_res_s;
      end
    end
  end

  assign bus.out_valid = out_valid_r;
  assign bus.gt        = res_r.gt;
  assign bus.lt        = res_r.lt;
  assign bus.eq        = res_r.eq;

`ifdef RELATIONAL_EXT_OUTPUTS_EN
  logic ge_r;
  logic le_r;
  logic ne_r;

  // Derived flags registered alongside the base result so they share its timing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ge_r <= 1'b0;
      le_r <= 1'b0;
      ne_r <= 1'b0;
    end else if (bus.in_valid) begin
      ge_r <= cmp_res_s.gt | cmp_res_s.eq;
      le_r <= cmp_res_s.lt | cmp_res_s.eq;
      ne_r <= ~cmp_res_s.eq;
    end
  end

  assign bus.ge = ge_r;
  assign bus.le = le_r;
  assign bus.ne = ne_r;
`endif

endmodule

// File: tb/tb_relational.sv
// Self-checking bench: WIDTH=1 and WIDTH=8 comparators against an integer
// reference model, plus directed boundary, hold and reset scenarios.
module tb_relational;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  // Expected {out_valid, gt, lt, eq} per instance.
  logic [3:0] exp1 = 4'b0000;
  logic [3:0] exp8 = 4'b0000;
  logic [3:0] obs1;
  logic [3:0] obs8;

  relational_if #(.WIDTH(1)) bus1 ();
  relational_if #(.WIDTH(8)) bus8 ();

  relational #(.WIDTH(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  relational #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

  always #5 clk = ~clk;

  assign obs1 = {bus1.out_valid, bus1.gt, bus1.lt, bus1.eq};
  assign obs8 = {bus8.out_valid, bus8.gt, bus8.lt, bus8.eq};

  // Reference: interpret operands as integers, then order them.
  function automatic logic [2:0] ref_cmp(input int w, input logic [7:0] x,
                                         input logic [7:0] y, input logic s);
    int m;
    int vx;
    int vy;
    m  = 1 << w;
    vx = int'(x) % m;
    vy = int'(y) % m;
    if (s && vx >= m / 2) vx = vx - m;
    if (s && vy >= m / 2) vy = vy - m;
    if (vx > vy) return 3'b100;
    if (vx < vy) return 3'b010;
    return 3'b001;
  endfunction

  // Apply one cycle of stimulus to both instances and advance the model.
  task automatic drive(input logic v1, input logic a1, input logic b1, input logic s1,
                       input logic v8, input logic [7:0] a8, input logic [7:0] b8,
                       input logic s8);
    bus1.in_valid = v1; bus1.a = a1; bus1.b = b1; bus1.cmp_signed = s1;
    bus8.in_valid = v8; bus8.a = a8; bus8.b = b8; bus8.cmp_signed = s8;
    @(posedge clk);
    exp1 = v1 ? {1'b1, ref_cmp(1, {7'd0, a1}, {7'd0, b1}, s1)} : {1'b0, exp1[2:0]};
    exp8 = v8 ? {1'b1, ref_cmp(8, a8, b8, s8)} : {1'b0, exp8[2:0]};
    #1;
  endtask

  task automatic test_reset();
    bus1.in_valid = 1'b1; bus1.a = 1'b1; bus1.b = 1'b0; bus1.cmp_signed = 1'b0;
    bus8.in_valid = 1'b1; bus8.a = 8'd9; bus8.b = 8'd2; bus8.cmp_signed = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (obs1 !== 4'b0000) begin
      bad++;
      $display("FAIL reset_w1 got %b want 0000", obs1);
    end
    total++;
    if (obs8 !== 4'b0000) begin
      bad++;
      $display("FAIL reset_w8 got %b want 0000", obs8);
    end
    rst_n = 1'b1;
    exp1 = 4'b0000;
    exp8 = 4'b0000;
  endtask

  task automatic test_w1_truth();
    logic [1:0] pairs [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
    logic [3:0] want  [4] = '{4'b1001, 4'b1010, 4'b1100, 4'b1001};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, pairs[i][1], pairs[i][0], 1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
      total++;
      if (obs1 !== want[i]) begin
        bad++;
        $display("FAIL w1_truth[%0d] got %b want %b", i, obs1, want[i]);
      end
    end
  endtask

  task automatic test_boundaries();
    logic [7:0] ta [6] = '{8'hFF, 8'hFF, 8'h80, 8'h80, 8'h00, 8'h00};
    logic [7:0] tb [6] = '{8'h01, 8'h01, 8'h7F, 8'h80, 8'hFF, 8'hFF};
    logic       ts [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [3:0] w8 [6] = '{4'b1100, 4'b1010, 4'b1010, 4'b1001, 4'b1010, 4'b1100};
    for (int i = 0; i < 6; i++) begin
      // Width-1 signed: 0 vs 1 means 0 vs -1, so gt.
      drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, ta[i], tb[i], ts[i]);
      total++;
      if (obs8 !== w8[i]) begin
        bad++;
        $display("FAIL bound8[%0d] got %b want %b", i, obs8, w8[i]);
      end
      total++;
      if (obs1 !== 4'b1100) begin
        bad++;
        $display("FAIL bound1_signed[%0d] got %b want 1100", i, obs1);
      end
    end
  endtask

  task automatic test_hold();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'hFF, 8'h01, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h55, 1'b1);
      total++;
      if (obs8 !== 4'b0100) begin
        bad++;
        $display("FAIL hold8[%0d] got %b want 0100", i, obs8);
      end
      total++;
      if (obs1 !== 4'b0100) begin
        bad++;
        $display("FAIL hold1[%0d] got %b want 0100", i, obs1);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] ra;
    logic [7:0] rb;
    for (int i = 0; i < 300; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = ($urandom_range(0, 3) == 0) ? ra : 8'($urandom_range(0, 255));
      drive(1'($urandom_range(0, 1)), ra[3], rb[5], 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) != 0), ra, rb, 1'($urandom_range(0, 1)));
      total++;
      if (obs8 !== exp8) begin
        bad++;
        $display("FAIL rand8[%0d] got %b want %b", i, obs8, exp8);
      end
      total++;
      if (obs1 !== exp1) begin
        bad++;
        $display("FAIL rand1[%0d] got %b want %b", i, obs1, exp1);
      end
    end
  endtask

  task automatic test_reset_in_flight();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd7, 8'd7, 1'b0);
    bus8.in_valid = 1'b1; bus8.a = 8'd5; bus8.b = 8'd3; bus8.cmp_signed = 1'b0;
    bus1.in_valid = 1'b1; bus1.a = 1'b1; bus1.b = 1'b0; bus1.cmp_signed = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (obs8 !== 4'b0000 || obs1 !== 4'b0000) begin
      bad++;
      $display("FAIL async_reset got %b/%b want 0000/0000", obs8, obs1);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp1 = 4'b0000;
    exp8 = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd5, 8'd3, 1'b0);
      total++;
      if (obs8 !== 4'b0000 || obs1 !== 4'b0000) begin
        bad++;
        $display("FAIL post_reset[%0d] got %b/%b want 0000/0000", i, obs8, obs1);
      end
    end
  endtask

`ifdef RELATIONAL_EXT_OUTPUTS_EN
  task automatic test_ext();
    logic [7:0] ea [3] = '{8'd3, 8'd5, 8'd3};
    logic [7:0] eb [3] = '{8'd3, 8'd3, 8'd5};
    logic [2:0] want;
    logic [2:0] got;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ea[i], eb[i], 1'b0);
      want = {int'(ea[i]) >= int'(eb[i]), int'(ea[i]) <= int'(eb[i]),
              int'(ea[i]) != int'(eb[i])};
      got  = {bus8.ge, bus8.le, bus8.ne};
      total++;
      if (got !== want || obs8 !== exp8) begin
        bad++;
        $display("FAIL ext[%0d] got gln=%b flags=%b want gln=%b flags=%b",
                 i, got, obs8, want, exp8);
      end
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd9, 8'd1, 1'b0);
    total++;
    if ({bus8.ge, bus8.le, bus8.ne} !== 3'b011) begin
      bad++;
      $display("FAIL ext_hold got %b want 011", {bus8.ge, bus8.le, bus8.ne});
    end
  endtask
`endif

  initial begin
    test_reset();
    test_w1_truth();
    test_boundaries();
    test_hold();
    test_random();
    test_reset_in_flight();
`ifdef RELATIONAL_EXT_OUTPUTS_EN
    test_ext();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
